// File: rtl/vga_copper.sv
// Display-list "copper": replays programmed register writes at chosen scanlines each frame.
// Optional list-complete interrupt is built only when VGA_COPPER_IRQ_EN is defined.
module vga_copper #(
   parameter int ENTRIES = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       frame_start,
   input  logic                       line_strobe,
   input  logic [9:0]                 line_y,
   input  logic                       prog_we,
   input  logic [$clog2(ENTRIES)-1:0] prog_addr,
   input  logic [20:0]                prog_data,
   input  logic                       ctrl_we,
   input  logic [5:0]                 ctrl_data,
   output logic                       cfg_valid,
   input  logic                       cfg_ready,
   output logic [1:0]                 cfg_target,
   output logic [8:0]                 cfg_value,
   output logic                       busy,
   output logic                       irq,
   input  logic                       irq_clear
);

   localparam int AW = $clog2(ENTRIES);
   localparam logic [4:0] MAX_COUNT = 5'(ENTRIES);

   typedef enum logic [2:0] {IDLE, WAIT_FRAME, WAIT_LINE, ISSUE, DONE} state_t;

   state_t      state, state_nx;
   logic [20:0] list_q [ENTRIES];
   logic [20:0] cur_entry;
   logic [4:0]  count, ptr, ptr_nx, count_wr;
   logic [9:0]  cur_line;
   logic        enable, cur_valid;
   logic        frame_rst, load_cfg;

   assign cur_entry = list_q[ptr[AW-1:0]];
   assign count_wr  = (ctrl_data[5:1] > MAX_COUNT) ? MAX_COUNT : ctrl_data[5:1];
   assign cfg_valid = (state == ISSUE);
   assign busy      = (state == WAIT_LINE) || (state == ISSUE);

   // ctrl_we outranks frame_start, which outranks normal list progress
   always_comb begin
      state_nx  = state;
      ptr_nx    = ptr;
      frame_rst = 1'b0;
      load_cfg  = 1'b0;
      if (ctrl_we) begin
         if (!ctrl_data[0]) begin
            state_nx = IDLE;
            ptr_nx   = 5'd0;
         end else if (state == IDLE) begin
            state_nx = WAIT_FRAME;
         end
      end else if (frame_start && enable) begin
         state_nx  = WAIT_LINE;
         ptr_nx    = 5'd0;
         frame_rst = 1'b1;
      end else begin
         case (state)
            WAIT_LINE: begin
               if (ptr == count) begin
                  state_nx = DONE;
               end else if (cur_valid && (cur_entry[20:11] <= cur_line)) begin
                  state_nx = ISSUE;
                  load_cfg = 1'b1;
               end
            end
            ISSUE: begin
               if (cfg_ready) begin
                  state_nx = WAIT_LINE;
                  ptr_nx   = ptr + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= 5'd0;
         count      <= 5'd0;
         enable     <= 1'b0;
         cur_valid  <= 1'b0;
         cfg_target <= 2'd0;
         cfg_value  <= 9'd0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
         if (ctrl_we) begin
            enable <= ctrl_data[0];
            count  <= count_wr;
         end
         // a strobe coinciding with frame_start still counts for the new frame
         if (line_strobe)
            cur_valid <= 1'b1;
         else if (frame_rst)
            cur_valid <= 1'b0;
         if (load_cfg) begin
            cfg_target <= cur_entry[10:9];
            cfg_value  <= cur_entry[8:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (line_strobe)
         cur_line <= line_y;
   end

   always_ff @(posedge clk) begin
      if (prog_we)
         list_q[prog_addr] <= prog_data;
   end

`ifdef VGA_COPPER_IRQ_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         irq <= 1'b0;
      else if ((state_nx == DONE) && (state != DONE))
         irq <= 1'b1;
      else if (irq_clear)
         irq <= 1'b0;
   end
`else
   logic unused_irq_clear;
   assign unused_irq_clear = irq_clear;
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_vga_copper.sv
// Directed table-driven bench for vga_copper; irq expectations follow VGA_COPPER_IRQ_EN.
module tb_vga_copper;

`ifdef VGA_COPPER_IRQ_EN
   localparam bit IRQ = 1'b1;
`else
   localparam bit IRQ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_start = 1'b0, line_strobe = 1'b0;
   logic [9:0]  line_y = '0;
   logic        prog_we = 1'b0;
   logic [2:0]  prog_addr = '0;
   logic [20:0] prog_data = '0;
   logic        ctrl_we = 1'b0;
   logic [5:0]  ctrl_data = '0;
   logic        cfg_valid, cfg_ready = 1'b0;
   logic [1:0]  cfg_target;
   logic [8:0]  cfg_value;
   logic        busy, irq, irq_clear = 1'b0;

   int nchk = 0;
   int nerr = 0;
   int hs_cnt = 0;

   vga_copper #(.ENTRIES(8)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_strobe(line_strobe),
      .line_y(line_y), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .ctrl_we(ctrl_we), .ctrl_data(ctrl_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_target(cfg_target), .cfg_value(cfg_value), .busy(busy), .irq(irq),
      .irq_clear(irq_clear)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cfg_valid && cfg_ready)
         hs_cnt <= hs_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit         fs, ls;
      logic [9:0] y;
      bit         rdy, clr;
      bit         ev;
      logic [1:0] et;
      logic [8:0] evl;
      bit         eb, ei;
      int         ehs;
   } row_t;

   row_t rows[$];

   function automatic void add(bit fs, bit ls, int y, bit rdy, bit clr,
                               bit ev, int et, int evl, bit eb, bit ei, int hs);
      row_t r;
      r.fs = fs; r.ls = ls; r.y = 10'(y); r.rdy = rdy; r.clr = clr;
      r.ev = ev; r.et = 2'(et); r.evl = 9'(evl); r.eb = eb; r.ei = ei; r.ehs = hs;
      rows.push_back(r);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input bit fs, input bit ls, input logic [9:0] y, input bit rdy, input bit clr);
      @(negedge clk);
      frame_start = fs; line_strobe = ls; line_y = y; cfg_ready = rdy; irq_clear = clr;
      prog_we = 1'b0; ctrl_we = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic prog(input int addr, input int line, input int tgt, input int val);
      @(negedge clk);
      frame_start = 1'b0; line_strobe = 1'b0; cfg_ready = 1'b0; irq_clear = 1'b0; ctrl_we = 1'b0;
      prog_we = 1'b1; prog_addr = 3'(addr); prog_data = {10'(line), 2'(tgt), 9'(val)};
      @(posedge clk);
      #1;
      prog_we = 1'b0;
   endtask

   task automatic ctrl(input int cnt, input bit en);
      @(negedge clk);
      frame_start = 1'b0; line_strobe = 1'b0; cfg_ready = 1'b0; irq_clear = 1'b0; prog_we = 1'b0;
      ctrl_we = 1'b1; ctrl_data = {5'(cnt), en};
      @(posedge clk);
      #1;
      ctrl_we = 1'b0;
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         cyc(rows[i].fs, rows[i].ls, rows[i].y, rows[i].rdy, rows[i].clr);
         chk($sformatf("row%0d cfg_valid", i), 32'(cfg_valid), 32'(rows[i].ev));
         chk($sformatf("row%0d busy", i), 32'(busy), 32'(rows[i].eb));
         chk($sformatf("row%0d irq", i), 32'(irq), 32'(rows[i].ei));
         chk($sformatf("row%0d handshakes", i), 32'(hs_cnt), 32'(rows[i].ehs));
         if (rows[i].ev) begin
            chk($sformatf("row%0d cfg_target", i), 32'(cfg_target), 32'(rows[i].et));
            chk($sformatf("row%0d cfg_value", i), 32'(cfg_value), 32'(rows[i].evl));
         end
      end
   endtask

   initial begin
      int sA, sB, sC, sD, sE, sF, sEnd, hs0;
      bit done;

      // fs, ls, y, rdy, clr | valid, tgt, val, busy, irq, handshakes
      sA = rows.size();
      add(1,0, 0,1,0, 0,0,0,   1,0,  0);
      add(0,1,10,1,0, 0,0,0,   1,0,  0);
      add(0,0, 0,1,0, 1,0,3,   1,0,  0);
      add(0,0, 0,1,0, 0,0,0,   1,0,  1);
      add(0,0, 0,1,0, 1,1,'h30,1,0,  1);
      add(0,0, 0,1,0, 0,0,0,   1,0,  2);
      add(0,0, 0,1,0, 0,0,0,   0,IRQ,2);
      add(0,0, 0,1,1, 0,0,0,   0,0,  2);
      sB = rows.size();
      add(1,0, 0,0,0, 0,0,0,   1,0,  2);
      add(0,1,10,0,0, 0,0,0,   1,0,  2);
      for (int k = 0; k < 6; k++) add(0,0,0,0,0, 1,0,3, 1,0, 2);
      add(0,0, 0,1,0, 0,0,0,   1,0,  3);
      add(0,0, 0,1,0, 1,1,'h30,1,0,  3);
      add(0,0, 0,1,0, 0,0,0,   1,0,  4);
      add(0,0, 0,0,0, 0,0,0,   0,IRQ,4);
      sC = rows.size();
      add(1,0, 0,1,0, 0,0,0,    1,IRQ,4);
      add(0,1, 3,1,0, 0,0,0,    1,IRQ,4);
      add(0,0, 0,1,0, 0,0,0,    1,IRQ,4);
      add(0,1, 7,1,0, 0,0,0,    1,IRQ,4);
      add(0,0, 0,1,0, 1,2,'h1AB,1,IRQ,4);
      add(0,0, 0,1,0, 0,0,0,    1,IRQ,5);
      add(0,0, 0,1,0, 0,0,0,    0,IRQ,5);
      add(0,0, 0,1,1, 0,0,0,    0,0,  5);
      sD = rows.size();
      add(1,0, 0,0,0, 0,0,0,    1,0,  5);
      add(0,1,10,0,0, 0,0,0,    1,0,  5);
      add(0,0, 0,0,0, 1,2,'h1AB,1,0,  5);
      add(0,0, 0,0,0, 1,2,'h1AB,1,0,  5);
      add(1,0, 0,0,0, 0,0,0,    1,0,  5);
      add(0,0, 0,0,0, 0,0,0,    1,0,  5);
      add(0,1, 5,1,0, 0,0,0,    1,0,  5);
      add(0,0, 0,1,0, 1,2,'h1AB,1,0,  5);
      add(0,0, 0,1,0, 0,0,0,    1,0,  6);
      add(0,0, 0,1,0, 0,0,0,    1,0,  6);
      add(0,1,10,1,0, 0,0,0,    1,0,  6);
      add(0,0, 0,1,0, 1,1,'h30, 1,0,  6);
      add(0,0, 0,1,0, 0,0,0,    1,0,  7);
      add(0,0, 0,1,0, 0,0,0,    0,IRQ,7);
      sE = rows.size();
      add(1,1,10,1,0, 0,0,0,    1,IRQ,7);
      add(0,0, 0,1,0, 1,2,'h1AB,1,IRQ,7);
      add(0,0, 0,1,0, 0,0,0,    1,IRQ,8);
      add(0,0, 0,1,0, 1,1,'h30, 1,IRQ,8);
      add(0,0, 0,1,0, 0,0,0,    1,IRQ,9);
      add(0,0, 0,1,0, 0,0,0,    0,IRQ,9);
      sF = rows.size();
      add(1,0, 0,1,1, 0,0,0,    1,0,  9);
      add(0,0, 0,1,1, 0,0,0,    0,IRQ,9);
      add(0,0, 0,1,0, 0,0,0,    0,IRQ,9);
      add(0,0, 0,1,1, 0,0,0,    0,0,  9);
      sEnd = rows.size();

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset cfg_valid", 32'(cfg_valid), 0);
      chk("reset cfg_target", 32'(cfg_target), 0);
      chk("reset cfg_value", 32'(cfg_value), 0);
      chk("reset busy", 32'(busy), 0);
      chk("reset irq", 32'(irq), 0);
      @(negedge clk);
      rst_n = 1'b1;

      prog(0, 10, 0, 'h03);
      prog(1, 10, 1, 'h30);
      ctrl(2, 1'b1);
      chk("wait_frame busy", 32'(busy), 0);
      run_rows(sA, sB);
      run_rows(sB, sC);
      prog(0, 5, 2, 'h1AB);
      ctrl(1, 1'b1);
      run_rows(sC, sD);
      ctrl(2, 1'b1);
      run_rows(sD, sE);
      run_rows(sE, sF);
      ctrl(0, 1'b1);
      run_rows(sF, sEnd);

      // count above ENTRIES is clamped: exactly 8 requests per frame
      for (int k = 0; k < 8; k++) prog(k, 0, k % 4, k * 3);
      ctrl(31, 1'b1);
      cyc(1'b1, 1'b1, 10'd0, 1'b1, 1'b0);
      hs0 = hs_cnt;
      done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         cyc(1'b0, 1'b0, 10'd0, 1'b1, 1'b0);
         if (!busy) done = 1'b1;
      end
      chk("clamp list finished", 32'(done), 1);
      chk("clamp handshakes", 32'(hs_cnt - hs0), 8);
      cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b1);

      // asynchronous reset while a request is pending
      ctrl(1, 1'b1);
      cyc(1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 10'd0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
      chk("pre-reset cfg_valid", 32'(cfg_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset cfg_valid", 32'(cfg_valid), 0);
      chk("async reset busy", 32'(busy), 0);
      chk("async reset cfg_value", 32'(cfg_value), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b1, 1'b1, 10'd0, 1'b1, 1'b0);
      chk("idle ignores frame", 32'(busy), 0);

      // disabling mid-request drops cfg_valid on the next cycle
      ctrl(1, 1'b1);
      cyc(1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 10'd0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
      chk("re-enable cfg_valid", 32'(cfg_valid), 1);
      ctrl(1, 1'b0);
      chk("disable cfg_valid", 32'(cfg_valid), 0);
      chk("disable busy", 32'(busy), 0);
      cyc(1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
      chk("disabled ignores frame", 32'(busy), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
